// File: rtl/fwd_arb_pkg.sv
// Shared definitions for the forwarder arbiter: FSM state encoding and a
// helper that sizes the granted-core index.
// Latency: n/a. Backpressure: n/a.
package fwd_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OFFER  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // A single core still needs a 1-bit index.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwd_arbiter_rr_pick.sv
// Purpose: round-robin picker; first set req bit at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; valid=0 when no request is set.
// Ports: req (N request bits), ptr (start index), valid (any request), idx (winner).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the farthest offset down to offset 0 so the closest requester
  // to ptr is the last one written and therefore wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/fwd_arbiter.sv
// Purpose: shares one forwarder among N_CORES cores, whole-packet round-robin.
// Latency: request -> rdy_for_fwd 2 cycles; claim and done acks pass through combinationally.
// Backpressure: an offer is held until claimed or withdrawn; done is held until the core acks.
// Ports: per-core fwd ports (core_*, sliced by index) on one side, a single
//   forwarder port (rdy_for_fwd/fwd_*) on the other; fwd_core_id = current grant.
module fwd_arbiter
  import fwd_arb_pkg::*;
#(
  parameter int  N_CORES           = 4,
  parameter int  SN_FWD_ADDR_WIDTH = 9,
  parameter int  SN_FWD_DATA_WIDTH = 64,
  parameter int  PLEN_WIDTH        = 32,
  localparam int ID_WIDTH          = id_width(N_CORES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_CORES-1:0]                     core_rdy_for_fwd,
  output logic [N_CORES-1:0]                     core_rdy_for_fwd_ack,
  output logic [N_CORES*SN_FWD_ADDR_WIDTH-1:0]   core_fwd_addr,
  output logic [N_CORES-1:0]                     core_fwd_rd_en,
  input  logic [N_CORES*SN_FWD_DATA_WIDTH-1:0]   core_fwd_rd_data,
  input  logic [N_CORES-1:0]                     core_fwd_rd_data_vld,
  input  logic [N_CORES*PLEN_WIDTH-1:0]          core_fwd_byte_len,
  output logic [N_CORES-1:0]                     core_fwd_done,
  input  logic [N_CORES-1:0]                     core_fwd_done_ack,
  output logic                                   rdy_for_fwd,
  input  logic                                   rdy_for_fwd_ack,
  input  logic [SN_FWD_ADDR_WIDTH-1:0]           fwd_addr,
  input  logic                                   fwd_rd_en,
  output logic [SN_FWD_DATA_WIDTH-1:0]           fwd_rd_data,
  output logic                                   fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]                  fwd_byte_len,
  input  logic                                   fwd_done,
  output logic                                   fwd_done_ack,
  output logic [ID_WIDTH-1:0]                    fwd_core_id
);

  state_t              r_state;
  logic [ID_WIDTH-1:0] r_grant;
  logic [ID_WIDTH-1:0] r_ptr;
  logic                r_rdy_for_fwd;

  logic                w_pick_vld;
  logic [ID_WIDTH-1:0] w_pick_idx;
  logic                w_live;
  logic                w_req_g;
  logic                w_claim;
  logic                w_release;
  logic [ID_WIDTH-1:0] w_next_ptr;
  logic [N_CORES-1:0]  w_sel;

  logic [SN_FWD_DATA_WIDTH-1:0] w_rd_data [N_CORES];
  logic [PLEN_WIDTH-1:0]        w_len     [N_CORES];

  rr_pick #(.N(N_CORES), .IW(ID_WIDTH)) u_pick (
    .req   (core_rdy_for_fwd),
    .ptr   (r_ptr),
    .valid (w_pick_vld),
    .idx   (w_pick_idx)
  );

  // Reset suppresses every handshake that would otherwise complete this cycle.
  assign w_live    = ~rst;
  assign w_req_g   = core_rdy_for_fwd[r_grant];
  // r_rdy_for_fwd is only ever set in OFFER; a withdrawn request beats a claim.
  assign w_claim   = r_rdy_for_fwd & rdy_for_fwd_ack & w_req_g & w_live;
  assign w_release = (r_state == ST_FINISH) & core_fwd_done_ack[r_grant] & w_live;
  assign w_next_ptr = (r_grant == ID_WIDTH'(N_CORES - 1)) ? '0 : r_grant + ID_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_ptr         <= '0;
      r_rdy_for_fwd <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant <= w_pick_idx;
            r_state <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (!w_req_g) begin
            r_state       <= ST_IDLE;
            r_rdy_for_fwd <= 1'b0;
          end else if (w_claim) begin
            r_state       <= ST_ACTIVE;
            r_rdy_for_fwd <= 1'b0;
            r_ptr         <= w_next_ptr;
          end else begin
            r_rdy_for_fwd <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (fwd_done) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          if (w_release) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_CORES; g++) begin : g_core
    assign w_sel[g]                = (r_state == ST_ACTIVE) && (r_grant == ID_WIDTH'(g));
    assign core_rdy_for_fwd_ack[g] = w_claim && (r_grant == ID_WIDTH'(g));
    assign core_fwd_rd_en[g]       = w_sel[g] & fwd_rd_en;
    assign core_fwd_addr[g*SN_FWD_ADDR_WIDTH +: SN_FWD_ADDR_WIDTH] = w_sel[g] ? fwd_addr : '0;
    assign core_fwd_done[g]        = (r_state == ST_FINISH) && (r_grant == ID_WIDTH'(g)) && w_live;
    assign w_rd_data[g]            = core_fwd_rd_data[g*SN_FWD_DATA_WIDTH +: SN_FWD_DATA_WIDTH];
    assign w_len[g]                = core_fwd_byte_len[g*PLEN_WIDTH +: PLEN_WIDTH];
  end

  assign rdy_for_fwd     = r_rdy_for_fwd;
  assign fwd_done_ack    = w_release;
  assign fwd_rd_data     = w_rd_data[r_grant];
  assign fwd_rd_data_vld = core_fwd_rd_data_vld[r_grant];
  assign fwd_byte_len    = w_len[r_grant];
  assign fwd_core_id     = r_grant;

endmodule

// File: tb/tb_fwd_arbiter.sv
// Bench for fwd_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a transaction-level model.
module tb_fwd_arbiter;
  localparam int N = 4, AW = 9, DW = 64, PL = 32, IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    core_rdy_for_fwd = '0, core_rdy_for_fwd_ack, core_fwd_rd_en;
  logic [N-1:0]    core_fwd_rd_data_vld = '0, core_fwd_done, core_fwd_done_ack = '0;
  logic [N*AW-1:0] core_fwd_addr;
  logic [N*DW-1:0] core_fwd_rd_data = '0;
  logic [N*PL-1:0] core_fwd_byte_len = '0;
  logic            rdy_for_fwd, rdy_for_fwd_ack = 1'b0;
  logic [AW-1:0]   fwd_addr = '0;
  logic            fwd_rd_en = 1'b0;
  logic [DW-1:0]   fwd_rd_data;
  logic            fwd_rd_data_vld;
  logic [PL-1:0]   fwd_byte_len;
  logic            fwd_done = 1'b0, fwd_done_ack;
  logic [IW-1:0]   fwd_core_id;

  fwd_arbiter #(.N_CORES(N), .SN_FWD_ADDR_WIDTH(AW), .SN_FWD_DATA_WIDTH(DW), .PLEN_WIDTH(PL)) dut (
    .clk(clk), .rst(rst),
    .core_rdy_for_fwd(core_rdy_for_fwd), .core_rdy_for_fwd_ack(core_rdy_for_fwd_ack),
    .core_fwd_addr(core_fwd_addr), .core_fwd_rd_en(core_fwd_rd_en),
    .core_fwd_rd_data(core_fwd_rd_data), .core_fwd_rd_data_vld(core_fwd_rd_data_vld),
    .core_fwd_byte_len(core_fwd_byte_len), .core_fwd_done(core_fwd_done),
    .core_fwd_done_ack(core_fwd_done_ack), .rdy_for_fwd(rdy_for_fwd),
    .rdy_for_fwd_ack(rdy_for_fwd_ack), .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en),
    .fwd_rd_data(fwd_rd_data), .fwd_rd_data_vld(fwd_rd_data_vld),
    .fwd_byte_len(fwd_byte_len), .fwd_done(fwd_done), .fwd_done_ack(fwd_done_ack),
    .fwd_core_id(fwd_core_id)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // m_offer_age: -1 = no packet on offer, else cycles since the core was picked.
  // A packet is on offer to the forwarder once it has aged one cycle.
  int m_grant = 0, m_ptr = 0, m_offer_age = -1;
  bit m_busy = 1'b0, m_fin = 1'b0;

  always @(posedge clk) begin
    bit found;
    int c;
    found = 1'b0;
    if (rst) begin
      m_grant = 0; m_ptr = 0; m_offer_age = -1; m_busy = 1'b0; m_fin = 1'b0;
    end else if (m_offer_age >= 0) begin
      if (!core_rdy_for_fwd[m_grant]) m_offer_age = -1;
      else if (m_offer_age >= 1 && rdy_for_fwd_ack) begin
        m_ptr = (m_grant + 1) % N;
        m_offer_age = -1;
        m_busy = 1'b1;
      end else m_offer_age = 1;
    end else if (m_busy) begin
      if (fwd_done) begin m_busy = 1'b0; m_fin = 1'b1; end
    end else if (m_fin) begin
      if (core_fwd_done_ack[m_grant]) m_fin = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && core_rdy_for_fwd[c]) begin
          found = 1'b1; m_grant = c; m_offer_age = 0;
        end
      end
    end
  end

  bit chk_en = 1'b0;
  logic [N-1:0] last_ack = '0;

  always @(negedge clk) begin
    logic [N-1:0]    e_ack, e_en, e_done;
    logic [N*AW-1:0] e_addr;
    bit live, offered;
    if (chk_en) begin
      live    = !rst;
      offered = (m_offer_age >= 1);
      e_ack  = (live && offered && core_rdy_for_fwd[m_grant] && rdy_for_fwd_ack) ? onehot(m_grant) : '0;
      e_en   = (m_busy && fwd_rd_en) ? onehot(m_grant) : '0;
      e_addr = '0;
      if (m_busy) e_addr[m_grant*AW +: AW] = fwd_addr;
      e_done = (live && m_fin) ? onehot(m_grant) : '0;
      chk("m_rdy_for_fwd", rdy_for_fwd, offered);
      chk("m_claim_ack", core_rdy_for_fwd_ack, e_ack);
      chk("m_rd_en", core_fwd_rd_en, e_en);
      chk("m_addr", core_fwd_addr, e_addr);
      chk("m_core_done", core_fwd_done, e_done);
      chk("m_done_ack", fwd_done_ack, live && m_fin && core_fwd_done_ack[m_grant]);
      chk("m_rd_data", fwd_rd_data, core_fwd_rd_data[m_grant*DW +: DW]);
      chk("m_rd_vld", fwd_rd_data_vld, core_fwd_rd_data_vld[m_grant]);
      chk("m_byte_len", fwd_byte_len, core_fwd_byte_len[m_grant*PL +: PL]);
      chk("m_core_id", fwd_core_id, m_grant);
    end
    last_ack = core_rdy_for_fwd_ack;
  end

  // ---------------- core read responders: data one cycle after rd_en ----------------
  logic [N-1:0]  pend = '0;
  logic [AW-1:0] pend_addr [N];

  function automatic logic [DW-1:0] data_of(input int i, input logic [AW-1:0] a);
    if (i == 3 && a == 9'h1A5) return 64'hDEADBEEF_CAFEF00D;
    return {32'hA500_0000 | 32'(i), 23'd0, a};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      pend[i]      = core_fwd_rd_en[i];
      pend_addr[i] = core_fwd_addr[i*AW +: AW];
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      core_fwd_rd_data_vld[i]      = pend[i];
      core_fwd_rd_data[i*DW +: DW] = pend[i] ? data_of(i, pend_addr[i]) : '0;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Wait for the offer, check the granted core, claim it and retire its request.
  task automatic claim(input int exp);
    int t;
    t = 0;
    @(negedge clk);
    while (rdy_for_fwd !== 1'b1 && t < 20) begin
      cyc();
      @(negedge clk);
      t++;
    end
    chk("claim_offer_seen", rdy_for_fwd, 1'b1);
    chk("claim_core_id", fwd_core_id, exp);
    cyc();
    rdy_for_fwd_ack = 1'b1;
    @(negedge clk);
    chk("claim_ack_onehot", core_rdy_for_fwd_ack, onehot(exp));
    cyc();
    rdy_for_fwd_ack = 1'b0;
    core_rdy_for_fwd[exp] = 1'b0;
  endtask

  task automatic finish_pkt(input int exp, input int dly);
    fwd_done = 1'b1;
    @(negedge clk);
    cyc();
    fwd_done = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("fin_done_held", core_fwd_done, onehot(exp));
      chk("fin_no_early_ack", fwd_done_ack, 1'b0);
      cyc();
    end
    core_fwd_done_ack[exp] = 1'b1;
    @(negedge clk);
    chk("fin_done_ack", fwd_done_ack, 1'b1);
    chk("fin_done_onehot", core_fwd_done, onehot(exp));
    cyc();
    core_fwd_done_ack = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) core_fwd_byte_len[i*PL +: PL] = $urandom_range(64, 1500);
    cyc();

    // 1: single request, 2-cycle offer latency, same-cycle claim ack
    do_reset();
    core_rdy_for_fwd = 4'b0010;
    @(negedge clk); chk("t1_rdy_c0", rdy_for_fwd, 1'b0);
    cyc();
    @(negedge clk); chk("t1_rdy_c1", rdy_for_fwd, 1'b0); chk("t1_id", fwd_core_id, 1);
    cyc();
    @(negedge clk); chk("t1_rdy_c2", rdy_for_fwd, 1'b1);
    cyc();
    rdy_for_fwd_ack = 1'b1;
    @(negedge clk); chk("t1_ack", core_rdy_for_fwd_ack, 4'b0010);
    cyc();
    rdy_for_fwd_ack = 1'b0;
    core_rdy_for_fwd = '0;
    finish_pkt(1, 1);

    // 2: simultaneous requests from ptr=0; core0 re-request waits behind core2
    do_reset();
    core_rdy_for_fwd = 4'b0101;
    claim(0);
    core_rdy_for_fwd[0] = 1'b1;
    finish_pkt(0, 1);
    claim(2);
    finish_pkt(2, 1);
    claim(0);
    finish_pkt(0, 1);

    // 3: read routed to core3 only, data back one cycle later
    core_rdy_for_fwd[3] = 1'b1;
    claim(3);
    fwd_addr  = 9'h1A5;
    fwd_rd_en = 1'b1;
    @(negedge clk);
    chk("t3_rd_en", core_fwd_rd_en, 4'b1000);
    chk("t3_addr", core_fwd_addr, 36'h1A5 << 27);
    cyc();
    fwd_rd_en = 1'b0;
    fwd_addr  = '0;
    @(negedge clk);
    chk("t3_vld", fwd_rd_data_vld, 1'b1);
    chk("t3_data", fwd_rd_data, 64'hDEADBEEF_CAFEF00D);
    cyc();

    // 4: done held for 5 cycles until the core acks
    finish_pkt(3, 5);

    // 5: withdrawn offer gets no ack and leaves ptr (now 0) alone
    core_rdy_for_fwd[1] = 1'b1;
    for (int t = 0; t < 20 && rdy_for_fwd !== 1'b1; t++) cyc();
    core_rdy_for_fwd[1] = 1'b0;
    rdy_for_fwd_ack = 1'b1;
    @(negedge clk); chk("t5_no_ack", core_rdy_for_fwd_ack, 4'b0000);
    cyc();
    rdy_for_fwd_ack = 1'b0;
    @(negedge clk); chk("t5_rdy_dropped", rdy_for_fwd, 1'b0);
    cyc();
    core_rdy_for_fwd = 4'b0110;
    claim(1);
    finish_pkt(1, 0);
    claim(2);
    finish_pkt(2, 0);

    // 6: reset in ACTIVE clears everything; next grant starts from core0
    core_rdy_for_fwd[2] = 1'b1;
    claim(2);
    fwd_rd_en = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    fwd_rd_en = 1'b0;
    core_rdy_for_fwd = 4'b1111;
    @(negedge clk);
    chk("t6_rdy", rdy_for_fwd, 1'b0);
    chk("t6_id", fwd_core_id, 0);
    chk("t6_rd_en", core_fwd_rd_en, 4'b0000);
    chk("t6_done", core_fwd_done, 4'b0000);
    cyc();
    claim(0);
    core_rdy_for_fwd = '0;
    finish_pkt(0, 0);

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (!core_rdy_for_fwd[i]) core_rdy_for_fwd[i] = ($urandom_range(0, 3) == 0);
        else if (last_ack[i] || $urandom_range(0, 39) == 0) core_rdy_for_fwd[i] = 1'b0;
      end
      rdy_for_fwd_ack   = (rdy_for_fwd && $urandom_range(0, 1) == 1) || ($urandom_range(0, 15) == 0);
      fwd_rd_en         = ($urandom_range(0, 2) == 0);
      fwd_addr          = AW'($urandom);
      fwd_done          = ($urandom_range(0, 7) == 0);
      core_fwd_done_ack = N'($urandom & $urandom);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
